omap_drain: RTL and testbench

Tile controller and result reader for a linear chain of complex-MAC PEs. It sequences one accumulation tile: it opens the feed window for the operand feeder, flushes the systolic skew, and captures every PE's packed complex `omap` in the same cycle. It then clears the PE accumulators and streams the captured results out one word per handshake. It sits between the PE chain's `omap` outputs and the output buffer/DMA writer.

---
 rtl/omap_drain_if.sv | 28 ++
 rtl/omap_drain.sv | 136 +++++++++++++
 tb/tb_omap_drain.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/omap_drain_if.sv
// Result stream from omap_drain to the output buffer / DMA writer.
// One word per out_valid && out_ready handshake.
interface omap_drain_if #(
  parameter int WORD_SIZE = 32,
  parameter int IDX_W     = 2
);
  logic [WORD_SIZE-1:0] out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/omap_drain.sv
// Tile controller for a complex-MAC PE chain: feed window, skew flush,
// single-cycle capture of all PE omaps with PE clear, then handshaked drain.
module omap_drain #(
  parameter int NUM_PE    = 4,
  parameter int WORD_SIZE = 32,
  parameter int KLEN_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [KLEN_W-1:0]           k_len,
  output logic                        feed_en,
  output logic                        pe_clr,
  input  logic [NUM_PE*WORD_SIZE-1:0] omap_in,
  omap_drain_if.master                out_if,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = (KLEN_W > IDX_W) ? KLEN_W : IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PE - 1);
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_CAPTURE,
    S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;
  logic [WORD_SIZE-1:0] buf_q [NUM_PE];
  logic                 accept;

  assign accept = (state_q == S_DRAIN) && out_if.out_ready;

  // cnt_q holds remaining cycles minus one, so k_len = 2^KLEN_W-1 loads
  // without overflow and the same counter serves both FEED and FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_d = S_FEED;
            cnt_d   = CNT_W'(k_len) - CNT_W'(1);
          end else begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_CNT;
          end
        end
      end
      S_FEED: begin
        if (cnt_q == '0) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_CNT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d = S_DRAIN;
        idx_d   = '0;
      end
      S_DRAIN: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // The PEs clear on the same edge that samples their final omap values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        buf_q[i] <= '0;
      end
    end else if (state_q == S_CAPTURE) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        buf_q[i] <= omap_in[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    feed_en          = (state_q == S_FEED);
    pe_clr           = rst || (state_q == S_CAPTURE);
    busy             = (state_q != S_IDLE);
    done             = done_q;
    out_if.out_valid = (state_q == S_DRAIN);
    out_if.out_idx   = idx_q;
    out_if.out_last  = (state_q == S_DRAIN) && (idx_q == LAST_IDX);
    out_if.out_data  = '0;
    if (state_q == S_DRAIN) begin
      out_if.out_data = buf_q[idx_q];
    end
  end

endmodule

// File: tb/tb_omap_drain.sv
// Bench for omap_drain: a behavioural PE chain supplies omap_in, and expected
// words are summed directly from the operands fed during the tile.
module tb_omap_drain;
  localparam int NUM_PE    = 4;
  localparam int WORD_SIZE = 32;
  localparam int KLEN_W    = 16;
  localparam int IDX_W     = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [KLEN_W-1:0]           k_len;
  logic                        feed_en;
  logic                        pe_clr;
  logic [NUM_PE*WORD_SIZE-1:0] omap_in;
  logic                        busy;
  logic                        done;

  omap_drain_if #(.WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)) oif ();

  omap_drain #(.NUM_PE(NUM_PE), .WORD_SIZE(WORD_SIZE), .KLEN_W(KLEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k_len   (k_len),
    .feed_en (feed_en),
    .pe_clr  (pe_clr),
    .omap_in (omap_in),
    .out_if  (oif),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Operand stream into PE0 and stationary per-PE weights.
  logic [31:0] imap;
  logic [31:0] w [NUM_PE];

  function automatic logic [15:0] cmul_re(input logic [31:0] a, input logic [31:0] b);
    int v;
    v = int'($signed(a[15:0])) * int'($signed(b[15:0]))
      - int'($signed(a[31:16])) * int'($signed(b[31:16]));
    return v[15:0];
  endfunction

  function automatic logic [15:0] cmul_im(input logic [31:0] a, input logic [31:0] b);
    int v;
    v = int'($signed(a[15:0])) * int'($signed(b[31:16]))
      + int'($signed(a[31:16])) * int'($signed(b[15:0]));
    return v[15:0];
  endfunction

  // Behavioural PE chain: operands shift one PE per cycle, each PE accumulates.
  logic [31:0] x_q [NUM_PE];
  logic [15:0] are [NUM_PE];
  logic [15:0] aim [NUM_PE];

  always @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (pe_clr) begin
        are[i] <= '0;
        aim[i] <= '0;
        x_q[i] <= '0;
      end else begin
        are[i] <= are[i] + cmul_re(x_q[i], w[i]);
        aim[i] <= aim[i] + cmul_im(x_q[i], w[i]);
        x_q[i] <= (i == 0) ? (feed_en ? imap : 32'h0) : x_q[(i == 0) ? 0 : i-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_omap
    assign omap_in[g*WORD_SIZE +: WORD_SIZE] = {aim[g], are[g]};
  end

  // Runs one tile starting in the current cycle (cycle 0); returns in the done cycle.
  task automatic run_tile(input int unsigned k, input int rmode, input bit rnd,
                          input bit poke, input string tag);
    int unsigned c;
    int unsigned cap_c;
    int unsigned idx;
    int unsigned budget;
    int unsigned ph;
    logic        r;
    logic [15:0] ere [NUM_PE];
    logic [15:0] eim [NUM_PE];
    for (int i = 0; i < NUM_PE; i++) begin
      w[i]   = rnd ? $urandom : 32'h0000_0003;
      ere[i] = '0;
      eim[i] = '0;
    end
    imap          = rnd ? $urandom : 32'h0001_0002;
    cap_c         = k + NUM_PE + 1;
    start         = 1'b1;
    k_len         = KLEN_W'(k);
    oif.out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_c0 got %b exp 0", tag, busy);
    end
    c = 0;
    while (c < cap_c) begin
      @(posedge clk); #1; c++;
      start = poke && (c == 2);
      k_len = KLEN_W'($urandom);
      if (rnd) imap = $urandom;
      if (c <= k) begin
        for (int i = 0; i < NUM_PE; i++) begin
          ere[i] = ere[i] + cmul_re(imap, w[i]);
          eim[i] = eim[i] + cmul_im(imap, w[i]);
        end
      end
      n_checks++;
      if (feed_en !== (c <= k)) begin
        n_fail++; $display("FAIL %s feed_en cyc %0d got %b exp %b", tag, c, feed_en, (c <= k));
      end
      n_checks++;
      if (pe_clr !== (c == cap_c)) begin
        n_fail++; $display("FAIL %s pe_clr cyc %0d got %b exp %b", tag, c, pe_clr, (c == cap_c));
      end
      n_checks++;
      if (busy !== 1'b1 || oif.out_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ctrl cyc %0d got busy=%b valid=%b done=%b exp 1/0/0",
                 tag, c, busy, oif.out_valid, done);
      end
    end
    idx    = 0;
    budget = 0;
    while (idx < NUM_PE && budget < 40) begin
      @(posedge clk); #1; c++; budget++;
      start = poke && (c == cap_c + 1);
      n_checks++;
      if (oif.out_valid !== 1'b1 || oif.out_idx !== IDX_W'(idx)) begin
        n_fail++;
        $display("FAIL %s drain_idx cyc %0d got valid=%b idx=%0d exp 1/%0d",
                 tag, c, oif.out_valid, oif.out_idx, idx);
      end
      n_checks++;
      if (oif.out_data !== {eim[idx], ere[idx]}) begin
        n_fail++;
        $display("FAIL %s data idx %0d got %h exp %h", tag, idx, oif.out_data, {eim[idx], ere[idx]});
      end
      n_checks++;
      if (oif.out_last !== (idx == NUM_PE - 1) || done !== 1'b0 || feed_en !== 1'b0 || pe_clr !== 1'b0) begin
        n_fail++;
        $display("FAIL %s drain_ctrl cyc %0d got last=%b done=%b feed=%b clr=%b exp %b/0/0/0",
                 tag, c, oif.out_last, done, feed_en, pe_clr, (idx == NUM_PE - 1));
      end
      ph = (budget - 1) % 5;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (ph == 1) || (ph == 4);
        default: r = 1'($urandom_range(0, 1));
      endcase
      oif.out_ready = r;
      if (r) idx++;
    end
    n_checks++;
    if (idx < NUM_PE) begin
      n_fail++; $display("FAIL %s drain_timeout got %0d words exp %0d", tag, idx, NUM_PE);
      oif.out_ready = 1'b0;
      start         = 1'b0;
      return;
    end
    @(posedge clk); #1; c++;
    oif.out_ready = 1'b0;
    start         = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || oif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle got done=%b busy=%b valid=%b exp 1/0/0", tag, done, busy, oif.out_valid);
    end
    if (rmode == 0) begin
      n_checks++;
      if (c !== k + 2*NUM_PE + 2) begin
        n_fail++; $display("FAIL %s done_time got cyc %0d exp %0d", tag, c, k + 2*NUM_PE + 2);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || oif.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle got done=%b busy=%b valid=%b exp 0/0/0", tag, done, busy, oif.out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (feed_en !== 1'b0 || pe_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got feed=%b clr=%b busy=%b done=%b exp 0/1/0/0", feed_en, pe_clr, busy, done);
    end
    n_checks++;
    if (oif.out_valid !== 1'b0 || oif.out_data !== 32'h0 || oif.out_idx !== 2'd0 || oif.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got valid=%b data=%h idx=%0d last=%b exp 0/0/0/0",
               oif.out_valid, oif.out_data, oif.out_idx, oif.out_last);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (pe_clr !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got clr=%b busy=%b exp 0/0", pe_clr, busy);
    end
  endtask

  task automatic test_basic();
    run_tile(3, 0, 1'b0, 1'b0, "basic");
    idle_cycles(2, "basic");
  endtask

  task automatic test_zero_len();
    run_tile(0, 0, 1'b0, 1'b0, "zero_len");
    idle_cycles(2, "zero_len");
  endtask

  task automatic test_backpressure();
    run_tile(5, 1, 1'b1, 1'b0, "backpressure");
    idle_cycles(2, "backpressure");
  endtask

  task automatic test_start_ignored();
    run_tile(4, 0, 1'b1, 1'b1, "start_ignored");
    run_tile(2, 0, 1'b1, 1'b0, "start_at_done");
    idle_cycles(2, "start_at_done");
  endtask

  task automatic test_abort();
    int unsigned abort_c;
    for (int p = 0; p < 2; p++) begin
      abort_c = (p == 0) ? 5 : 11;
      for (int i = 0; i < NUM_PE; i++) w[i] = 32'h0000_0003;
      imap          = 32'h0001_0002;
      start         = 1'b1;
      k_len         = 16'd3;
      oif.out_ready = 1'b1;
      for (int unsigned c = 1; c <= abort_c; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (p == 1) begin
        n_checks++;
        if (oif.out_valid !== 1'b1 || oif.out_idx !== 2'd2) begin
          n_fail++;
          $display("FAIL abort_pre got valid=%b idx=%0d exp 1/2", oif.out_valid, oif.out_idx);
        end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      oif.out_ready = 1'b0;
      n_checks++;
      if (feed_en !== 1'b0 || pe_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort%0d_ctrl got feed=%b clr=%b busy=%b done=%b exp 0/1/0/0",
                 p, feed_en, pe_clr, busy, done);
      end
      n_checks++;
      if (oif.out_valid !== 1'b0 || oif.out_data !== 32'h0 || oif.out_idx !== 2'd0 || oif.out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL abort%0d_out got valid=%b data=%h idx=%0d last=%b exp 0/0/0/0",
                 p, oif.out_valid, oif.out_data, oif.out_idx, oif.out_last);
      end
      rst = 1'b0;
      idle_cycles(3, "abort");
    end
    run_tile(3, 0, 1'b0, 1'b0, "post_abort");
    idle_cycles(2, "post_abort");
  endtask

  task automatic test_back_to_back();
    run_tile(1, 0, 1'b1, 1'b0, "b2b_first");
    run_tile(2, 0, 1'b1, 1'b0, "b2b_second");
    idle_cycles(1, "b2b");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_tile($urandom_range(0, 9), 2, 1'b1, 1'($urandom_range(0, 1)), "random");
    end
    idle_cycles(2, "random");
  endtask

  task automatic test_max_klen();
    run_tile(65535, 0, 1'b0, 1'b0, "max_klen");
    idle_cycles(2, "max_klen");
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    k_len         = '0;
    imap          = '0;
    oif.out_ready = 1'b0;
    for (int i = 0; i < NUM_PE; i++) w[i] = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    test_max_klen();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
